spi_byte_sequencer: RTL

SPI_BYTE_SEQUENCER -- requirements
Module: spi_byte_sequencer

---
 rtl/spi_pkg.sv | 14 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/spi_byte_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared width and FSM state type for the SPI byte sequencer
package spi_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LAUNCH     = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_CAPTURE    = 3'd4
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous first-word-fall-through FIFO
// Ports: clk, rst (sync, active high); push/push_data/full on the write side;
//        pop/pop_data/empty on the read side. pop_data shows the head entry
//        and reads as zero while the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO and a pop from an empty one are dropped; the
  // full flag is taken before any same-cycle pop.
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/spi_byte_sequencer.sv
// rtl/spi_byte_sequencer.sv - feeds host bytes to an SPI master and collects replies
// Ports: clk, rst (sync, active high)
//        tx_data/tx_valid/tx_ready : host bytes into the TX FIFO
//        rx_data/rx_valid/rx_ready : replies out of the RX FIFO
//        m_in_data/m_wr/m_rd       : strobes and data towards the SPI master
//        m_out_data/m_cs           : reply byte and active-low busy from the master
//        err                       : sticky start timeout, busy : FSM not idle
module spi_byte_sequencer
  import spi_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] m_in_data,
  output logic              m_wr,
  output logic              m_rd,
  input  logic [DATA_W-1:0] m_out_data,
  input  logic              m_cs,
  output logic              err,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] m_in_data_q, m_in_data_d;

  logic [DATA_W-1:0] tx_head;
  logic              tx_full, tx_empty, tx_pop;
  logic              rx_full, rx_empty, rx_push;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_valid),
    .push_data (tx_data),
    .full      (tx_full),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .empty     (tx_empty)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (m_out_data),
    .full      (rx_full),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .empty     (rx_empty)
  );

  assign tx_ready  = !tx_full;
  assign rx_valid  = !rx_empty;
  assign m_in_data = m_in_data_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    m_in_data_d = m_in_data_q;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    m_wr        = 1'b0;
    m_rd        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only start when the reply is guaranteed a slot in the RX FIFO.
        // The RX count cannot grow again before CAPTURE since only this
        // FSM pushes it.
        if (!tx_empty && !rx_full) begin
          state_d     = ST_LAUNCH;
          m_in_data_d = tx_head;
        end
      end
      ST_LAUNCH: begin
        m_wr    = 1'b1;
        tx_pop  = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        // Counter starts at 0 on the first wait cycle, so the timeout lands
        // on the TIMEOUT-th wait cycle and err is visible one cycle later.
        if (!m_cs) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (m_cs) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        m_rd    = 1'b1;
        rx_push = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      m_in_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      m_in_data_q <= m_in_data_d;
    end
  end

endmodule
